mem_arbiter: RTL

Two-requester arbiter that shares the single data memory port between instruction fetch and load/store. It sits between the fetch/memory stages of the multicycle core and the `mem` array. It issues one transaction at a time, tracks a fixed memory read latency, routes each response to the requester that owns it, and supports fetch-response squash on control-flow redirect.

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and load/store.
// One transaction outstanding at a time; responses are routed to the owner after a fixed latency.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 15,
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [2:0]            d_type,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [2:0]            mem_type,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} owner_e;

  localparam logic [2:0] LP_LAT = 3'(LATENCY);
  localparam logic [3:0] LP_SL  = 4'(STARVE_LIMIT);

  logic [2:0] r_cnt;
  owner_e     r_owner;
  logic       r_owner_we;
  logic       r_squash;
  logic [3:0] r_skip;

  logic w_can_acc;
  logic w_if_elig;
  logic w_fetch_win;
  logic w_data_win;
  logic w_acc;
  logic w_resp;

  // Data wins by default; fetch takes the port once it has lost STARVE_LIMIT contended rounds.
  assign w_can_acc   = (r_cnt <= 3'd1);
  assign w_if_elig   = if_req & ~if_flush;
  assign w_fetch_win = w_if_elig & (~d_req | (r_skip == LP_SL));
  assign w_data_win  = d_req & ~w_fetch_win;
  assign w_acc       = ~rst & w_can_acc & (w_fetch_win | w_data_win);
  assign w_resp      = ~rst & (r_cnt == 3'd1);

  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_type  = '0;
    if (w_acc) begin
      mem_en = 1'b1;
      if (w_fetch_win) begin
        if_gnt   = 1'b1;
        mem_addr = if_addr;
      end else begin
        d_gnt     = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_type  = d_type;
      end
    end
  end

  // A flush in the response cycle itself must also drop the fetch data.
  always_comb begin
    if_rvalid = w_resp & (r_owner == OWN_FETCH) & ~r_squash & ~if_flush;
    d_rvalid  = w_resp & (r_owner == OWN_DATA);
    if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    d_rdata   = (d_rvalid & ~r_owner_we) ? mem_rdata : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 3'd0;
      r_owner    <= OWN_FETCH;
      r_owner_we <= 1'b0;
      r_squash   <= 1'b0;
      r_skip     <= 4'd0;
    end else begin
      if (w_acc) begin
        r_cnt      <= LP_LAT;
        r_owner    <= w_data_win ? OWN_DATA : OWN_FETCH;
        r_owner_we <= d_we & w_data_win;
        r_squash   <= 1'b0;
      end else begin
        if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
        // Counting continues so the memory timing is unaffected by the squash.
        if (if_flush && (r_cnt != 3'd0) && (r_owner == OWN_FETCH)) r_squash <= 1'b1;
      end
      if (d_gnt && w_if_elig) begin
        if (r_skip != LP_SL) r_skip <= r_skip + 4'd1;
      end else if (if_gnt || !if_req) begin
        r_skip <= 4'd0;
      end
    end
  end

endmodule
